// File: rtl/fml_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fml_fetch_if
// Description : Bus bundle for fml_fetch. It carries the read-only FML master
//               port (adr/stb/we/ack/di) and the pixel stream toward the VGA
//               formatter (data/valid/ready).
//   master : the fetch engine (drives FML request, produces pixel words)
//   slave  : the far side (DDR controller FML port + pixel consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface fml_fetch_if #(
    parameter int sdram_depth = 26
);
    // FML read port
    logic [sdram_depth-1:0] fml_adr;
    logic                   fml_stb;
    logic                   fml_we;
    logic                   fml_ack;
    logic [63:0]            fml_di;

    // Pixel stream, show-ahead FIFO head
    logic [63:0]            pix_data;
    logic                   pix_valid;
    logic                   pix_ready;

    modport master (
        output fml_adr,
        output fml_stb,
        output fml_we,
        input  fml_ack,
        input  fml_di,
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  fml_adr,
        input  fml_stb,
        input  fml_we,
        output fml_ack,
        output fml_di,
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/fml_fetch.sv
`default_nettype none
// ============================================================================
// Module      : fml_fetch
// Description : Read-only FML master streaming a linear SDRAM region into a
//               small FIFO for VGA scan-out. Each frame_start latches a base
//               address and burst count, then 4-beat x 64-bit read bursts are
//               issued while the FIFO has room for a whole burst.
// Ports       :
//   sys_clk      - single rising-edge clock
//   sys_rst_n    - asynchronous active-low reset
//   frame_start  - one-cycle pulse: latch base/nbursts, flush FIFO, start frame
//   base         - frame start byte address (low 5 bits ignored)
//   nbursts      - number of 32-byte bursts in the frame
//   busy         - frame in progress until its last word is written
//   underflow    - consumer wanted data during a frame but FIFO was empty
//   bus          - fml_fetch_if.master: FML request port + pixel stream
// Revision    : 1.0 - initial release
// ============================================================================
module fml_fetch #(
    parameter int sdram_depth     = 26,
    parameter int fifo_depth_log2 = 5,
    parameter int len_width       = 17
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   frame_start,
    input  logic [sdram_depth-1:0] base,
    input  logic [len_width-1:0]   nbursts,
    output logic                   busy,
    output logic                   underflow,
    fml_fetch_if.master            bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    localparam int c_lvl_w = fifo_depth_log2 + 1;
    localparam int c_words = 1 << fifo_depth_log2;

    localparam logic [c_lvl_w-1:0]     c_depth      = c_lvl_w'(c_words);
    // Highest fill level that still leaves room for a full 4-beat burst
    localparam logic [c_lvl_w-1:0]     c_gate_max   = c_lvl_w'(c_words - 4);
    localparam logic [c_lvl_w-1:0]     c_lvl_one    = c_lvl_w'(1);
    localparam logic [sdram_depth-1:0] c_align_mask = ~sdram_depth'(31);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]                 r_state;
    logic [1:0]                 r_beat;
    logic                       r_discard;
    logic [sdram_depth-1:0]     r_base;
    logic [len_width-1:0]       r_nbursts;
    logic [len_width-1:0]       r_burst_idx;
    logic [sdram_depth-1:0]     r_adr;
    logic                       r_busy;

    logic [63:0]                r_mem [c_words];
    logic [fifo_depth_log2-1:0] r_wr_ptr;
    logic [fifo_depth_log2-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0]         r_level;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [sdram_depth-1:0] w_base_al;
    logic [sdram_depth-1:0] w_offset;
    logic [sdram_depth-1:0] w_adr_next;
    logic                   w_start_nz;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_gate;
    logic [c_lvl_w-1:0]     w_level_next;

    assign w_base_al  = base & c_align_mask;
    assign w_start_nz = (nbursts != '0);

    // Burst address is base + idx*32, truncated so it wraps past the top of
    // the SDRAM space instead of overflowing.
    assign w_offset   = sdram_depth'({r_burst_idx, 5'b00000});
    assign w_adr_next = r_base + w_offset;

    // Beats of a burst belonging to an aborted frame are never written, and a
    // frame_start cycle never writes so the flush cannot be undone.
    assign w_push = (r_state == S_DATA) && !r_discard && !frame_start;
    assign w_pop  = bus.pix_ready && (r_level != '0) && !frame_start;

    always_comb begin
        w_level_next = r_level;
        if (frame_start) begin
            w_level_next = '0;
        end else if (w_push && !w_pop) begin
            w_level_next = r_level + c_lvl_one;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - c_lvl_one;
        end
    end

    // Gate looks at the level as it will be once this cycle's push/pop land,
    // i.e. the occupancy seen on the cycle REQ is entered. With at most one
    // burst outstanding this guarantees the FIFO never overflows.
    assign w_gate = (w_level_next <= c_gate_max);

    // ------------------------------------------------------------------------
    // Request / frame FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_beat      <= 2'd0;
            r_discard   <= 1'b0;
            r_base      <= '0;
            r_nbursts   <= '0;
            r_burst_idx <= '0;
            r_adr       <= '0;
            r_busy      <= 1'b0;
        end else if (frame_start) begin
            r_base      <= w_base_al;
            r_nbursts   <= nbursts;
            r_burst_idx <= '0;
            r_busy      <= w_start_nz;
            if ((r_state == S_REQ) ||
                ((r_state == S_DATA) && (r_beat != 2'd3))) begin
                // A strobe cannot be withdrawn and accepted beats must still
                // arrive, so the old burst is drained and dropped; the new
                // frame is launched when its last beat has gone by.
                r_discard <= 1'b1;
                if (r_state == S_REQ) begin
                    if (bus.fml_ack) begin
                        r_state <= S_DATA;
                        r_beat  <= 2'd0;
                    end
                end else begin
                    r_beat <= r_beat + 2'd1;
                end
            end else begin
                // Nothing in flight (or the last beat is passing right now):
                // the new frame starts immediately.
                r_discard <= 1'b0;
                r_beat    <= 2'd0;
                if (w_start_nz) begin
                    r_state <= S_REQ;
                    r_adr   <= w_base_al;
                end else begin
                    r_state <= S_IDLE;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_REQ: begin
                    if (bus.fml_ack) begin
                        r_state <= S_DATA;
                        r_beat  <= 2'd0;
                        if (!r_discard) begin
                            r_burst_idx <= r_burst_idx + len_width'(1);
                        end
                    end
                end
                S_DATA: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_discard <= 1'b0;
                        // After a drained abort burst_idx is 0, so an empty
                        // restarted frame lands in IDLE here as well.
                        if (r_burst_idx == r_nbursts) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_gate) begin
                            r_state <= S_REQ;
                            r_adr   <= w_adr_next;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_gate) begin
                        r_state <= S_REQ;
                        r_adr   <= w_adr_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage (no reset needed: validity is tracked by the level)
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.fml_di;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_level <= w_level_next;
            if (frame_start) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + fifo_depth_log2'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + fifo_depth_log2'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.fml_adr   = r_adr;
    assign bus.fml_stb   = (r_state == S_REQ);
    assign bus.fml_we    = 1'b0;
    assign bus.pix_data  = r_mem[r_rd_ptr];
    assign bus.pix_valid = (r_level != '0) && (r_level <= c_depth);
    assign busy          = r_busy;
    // Only meaningful while a frame is running; outside a frame an empty
    // FIFO is expected and is not reported.
    assign underflow     = bus.pix_ready && !bus.pix_valid && r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fml_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fml_fetch
// Description : Self-checking directed bench for fml_fetch with a small FML
//               slave model (programmable ack delay, address-tagged beats)
//               and a pixel-stream monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fml_fetch;
    localparam int c_sd = 26;
    localparam int c_fd = 3;
    localparam int c_lw = 17;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              frame_start;
    logic [c_sd-1:0]   base;
    logic [c_lw-1:0]   nbursts;
    logic              busy;
    logic              underflow;

    fml_fetch_if #(.sdram_depth(c_sd)) bus ();

    fml_fetch #(
        .sdram_depth    (c_sd),
        .fifo_depth_log2(c_fd),
        .len_width      (c_lw)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .frame_start(frame_start),
        .base       (base),
        .nbursts    (nbursts),
        .busy       (busy),
        .underflow  (underflow),
        .bus        (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int              n_chk = 0;
    int              n_bad = 0;
    int              ack_delay = 3;
    int              uf_cnt = 0;
    int              stb_seen = 0;
    logic            ovf_seen = 1'b0;
    logic [c_sd-1:0] adr_q[$];
    logic [63:0]     got_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Beat b of the burst at address a carries the address and beat number
    function automatic logic [63:0] beat_word(input logic [c_sd-1:0] a, input int b);
        return {6'd0, a, 30'd0, 2'(b)};
    endfunction

    function automatic logic [c_sd-1:0] q_adr(input int i);
        return (adr_q.size() > i) ? adr_q[i] : '1;
    endfunction

    function automatic logic [63:0] q_word(input int i);
        return (got_q.size() > i) ? got_q[i] : '1;
    endfunction

    task automatic clear_logs();
        adr_q.delete();
        got_q.delete();
        uf_cnt   = 0;
        stb_seen = 0;
    endtask

    task automatic start_frame(input logic [c_sd-1:0] b, input logic [c_lw-1:0] n);
        @(negedge sys_clk);
        frame_start = 1'b1;
        base        = b;
        nbursts     = n;
        @(negedge sys_clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge sys_clk);
            if (!busy) break;
        end
        if (k >= limit) chk(tag, 1'b1, 1'b0);
    endtask

    // FML slave: ack after ack_delay strobe cycles, then 4 beats back to back
    initial begin : slave
        int              wait_cnt;
        int              beat_cnt;
        logic [c_sd-1:0] lat;
        wait_cnt    = 0;
        beat_cnt    = 0;
        lat         = '0;
        bus.fml_ack = 1'b0;
        bus.fml_di  = '0;
        forever begin
            @(negedge sys_clk);
            bus.fml_ack = 1'b0;
            if (beat_cnt > 0) begin
                bus.fml_di = beat_word(lat, 4 - beat_cnt);
                beat_cnt--;
            end else if (bus.fml_stb) begin
                wait_cnt++;
                if (wait_cnt > ack_delay) begin
                    bus.fml_ack = 1'b1;
                    lat         = bus.fml_adr;
                    adr_q.push_back(lat);
                    wait_cnt    = 0;
                    beat_cnt    = 4;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Pixel / status monitor, sampled mid-cycle after inputs settle
    initial begin : monitor
        forever begin
            @(negedge sys_clk);
            #1;
            if (sys_rst_n && bus.pix_valid && bus.pix_ready) got_q.push_back(bus.pix_data);
            if (underflow) uf_cnt++;
            if (bus.fml_stb) stb_seen++;
        end
    end

    always @(posedge sys_clk) begin
        if (dut.w_push && (dut.r_level == 4'd8)) ovf_seen <= 1'b1;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [c_sd-1:0] t2_adr [4];
        logic            got_ack;
        t2_adr = '{26'h0000100, 26'h0000120, 26'h0000140, 26'h0000160};

        frame_start   = 1'b0;
        base          = '0;
        nbursts       = '0;
        bus.pix_ready = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge sys_clk);
        chk("rst_stb",   bus.fml_stb,   1'b0);
        chk("rst_adr",   bus.fml_adr,   26'h0);
        chk("rst_we",    bus.fml_we,    1'b0);
        chk("rst_valid", bus.pix_valid, 1'b0);
        chk("rst_busy",  busy,          1'b0);
        chk("rst_uflow", underflow,     1'b0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // ---------------- basic frame ----------------
        clear_logs();
        ack_delay     = 3;
        bus.pix_ready = 1'b1;
        start_frame(26'h0001010, 17'd2);
        chk("t1_stb_rise", bus.fml_stb, 1'b1);
        chk("t1_adr0",     bus.fml_adr, 26'h0001000);
        chk("t1_busy",     busy,        1'b1);
        wait_done("t1_timeout", 200);
        repeat (3) @(negedge sys_clk);
        chk("t1_nreq", adr_q.size(), 2);
        chk("t1_req0", q_adr(0), 26'h0001000);
        chk("t1_req1", q_adr(1), 26'h0001020);
        chk("t1_nword", got_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t1_word%0d", i), q_word(i),
                beat_word((i < 4) ? 26'h0001000 : 26'h0001020, i % 4));
        chk("t1_uflow_cycles", uf_cnt, 9);
        chk("t1_busy_end", busy, 1'b0);

        // ---------------- back-pressure ----------------
        clear_logs();
        ack_delay     = 2;
        bus.pix_ready = 1'b0;
        start_frame(26'h0000100, 17'd4);
        repeat (40) @(negedge sys_clk);
        chk("t2_nreq_full", adr_q.size(), 2);
        chk("t2_stb_low",   bus.fml_stb, 1'b0);
        chk("t2_level",     dut.r_level, 4'd8);
        chk("t2_valid",     bus.pix_valid, 1'b1);
        bus.pix_ready = 1'b1;
        repeat (4) @(negedge sys_clk);
        bus.pix_ready = 1'b0;
        for (int i = 0; i < 20 && adr_q.size() < 3; i++) @(negedge sys_clk);
        chk("t2_nreq_after_pop", adr_q.size(), 3);
        chk("t2_req2", q_adr(2), 26'h0000140);
        repeat (2) @(negedge sys_clk);
        chk("t2_popped", got_q.size(), 4);
        bus.pix_ready = 1'b1;
        wait_done("t2_timeout", 300);
        repeat (3) @(negedge sys_clk);
        chk("t2_nword", got_q.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t2_word%0d", i), q_word(i), beat_word(t2_adr[i / 4], i % 4));

        // ---------------- restart during REQ ----------------
        clear_logs();
        ack_delay     = 6;
        bus.pix_ready = 1'b1;
        start_frame(26'h0004000, 17'd3);
        @(negedge sys_clk);
        start_frame(26'h0002000, 17'd1);
        chk("t3_stb_hold", bus.fml_stb, 1'b1);
        chk("t3_adr_hold", bus.fml_adr, 26'h0004000);
        repeat (2) @(negedge sys_clk);
        chk("t3_stb_hold2", bus.fml_stb, 1'b1);
        chk("t3_adr_hold2", bus.fml_adr, 26'h0004000);
        wait_done("t3_timeout", 200);
        repeat (3) @(negedge sys_clk);
        chk("t3_nreq", adr_q.size(), 2);
        chk("t3_req0", q_adr(0), 26'h0004000);
        chk("t3_req1", q_adr(1), 26'h0002000);
        chk("t3_nword", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_word%0d", i), q_word(i), beat_word(26'h0002000, i));

        // ---------------- flush with empty frame, idle underflow ----------------
        clear_logs();
        ack_delay     = 1;
        bus.pix_ready = 1'b0;
        start_frame(26'h0000300, 17'd1);
        wait_done("t4_timeout", 100);
        chk("t4_valid_before", bus.pix_valid, 1'b1);
        start_frame(26'h0000000, 17'd0);
        chk("t4_flush_valid", bus.pix_valid, 1'b0);
        chk("t4_flush_busy",  busy,          1'b0);
        chk("t4_flush_stb",   bus.fml_stb,   1'b0);
        uf_cnt        = 0;
        bus.pix_ready = 1'b1;
        repeat (5) @(negedge sys_clk);
        bus.pix_ready = 1'b0;
        chk("t4_no_uflow_idle", uf_cnt, 0);
        chk("t4_no_pop", got_q.size(), 0);

        // ---------------- address wrap ----------------
        clear_logs();
        ack_delay     = 2;
        bus.pix_ready = 1'b1;
        start_frame(26'h3FFFFE0, 17'd2);
        wait_done("t5_timeout", 200);
        repeat (3) @(negedge sys_clk);
        chk("t5_req0", q_adr(0), 26'h3FFFFE0);
        chk("t5_req1", q_adr(1), 26'h0000000);
        chk("t5_nword", got_q.size(), 8);
        chk("t5_word4", q_word(4), beat_word(26'h0000000, 0));

        // ---------------- async reset mid-DATA ----------------
        clear_logs();
        ack_delay     = 1;
        bus.pix_ready = 1'b0;
        got_ack       = 1'b0;
        start_frame(26'h0000500, 17'd2);
        for (int i = 0; i < 20 && !got_ack; i++) begin
            @(negedge sys_clk);
            #1;
            if (bus.fml_ack) got_ack = 1'b1;
        end
        chk("t6_ack_seen", got_ack, 1'b1);
        repeat (2) @(negedge sys_clk);
        #1;
        chk("t6_pre_valid", bus.pix_valid, 1'b1);
        chk("t6_pre_busy",  busy,          1'b1);
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_stb",   bus.fml_stb,   1'b0);
        chk("t6_rst_adr",   bus.fml_adr,   26'h0);
        chk("t6_rst_we",    bus.fml_we,    1'b0);
        chk("t6_rst_valid", bus.pix_valid, 1'b0);
        chk("t6_rst_busy",  busy,          1'b0);
        chk("t6_rst_uflow", underflow,     1'b0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        stb_seen  = 0;
        repeat (10) @(negedge sys_clk);
        chk("t6_quiet_stb",   stb_seen,      0);
        chk("t6_quiet_valid", bus.pix_valid, 1'b0);
        chk("t6_quiet_busy",  busy,          1'b0);

        chk("no_overflow", ovf_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
